// File: rtl/vram_arbiter_pkg.sv
// Shared constants for the video RAM arbiter: default widths, fill FSM
// encoding and the requester IDs carried down the read-return pipeline.
package vram_pkg;

  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 8;
  localparam int VRAM_LW = 15;

  localparam logic [1:0] FILL_IDLE = 2'd0;
  localparam logic [1:0] FILL_RUN  = 2'd1;
  localparam logic [1:0] FILL_DONE = 2'd2;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_NONE = 2'd0;
  localparam req_id_t REQ_VID  = 2'd1;
  localparam req_id_t REQ_CPU  = 2'd2;
  localparam req_id_t REQ_FILL = 2'd3;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the video RAM arbiter.
// slave = arbiter view, master = requesters plus RAM model view.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW,
  parameter int LW = VRAM_LW
);

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          fill_start;
  logic          fill_abort;
  logic [AW-1:0] fill_base;
  logic [LW-1:0] fill_len;
  logic [DW-1:0] fill_data;
  logic          fill_busy;
  logic          fill_done;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  fill_start, fill_abort, fill_base, fill_len, fill_data,
    input  mem_dout,
    output vid_rvalid, vid_rdata,
    output cpu_ack, cpu_rdata,
    output fill_busy, fill_done,
    output mem_addr, mem_we, mem_din
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output fill_start, fill_abort, fill_base, fill_len, fill_data,
    output mem_dout,
    input  vid_rvalid, vid_rdata,
    input  cpu_ack, cpu_rdata,
    input  fill_busy, fill_done,
    input  mem_addr, mem_we, mem_din
  );

endinterface

// File: rtl/vram_fill_engine.sv
// Block-fill engine: walks an address range writing one constant byte,
// requesting the RAM every cycle while running.
module vram_fill_engine
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW,
  parameter int LW = VRAM_LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [AW-1:0] i_base,
  input  logic [LW-1:0] i_len,
  input  logic [DW-1:0] i_data,
  input  logic          i_gnt,
  output logic          o_req,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_busy,
  output logic          o_done
);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_cnt;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FILL_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        FILL_IDLE: begin
          if (i_start) begin
            r_addr  <= i_base;
            r_cnt   <= i_len;
            r_data  <= i_data;
            r_state <= (i_len == '0) ? FILL_DONE : FILL_RUN;
          end
        end
        FILL_RUN: begin
          if (i_gnt) begin
            r_addr <= r_addr + AW'(1);
            r_cnt  <= r_cnt - LW'(1);
          end
          // A write granted alongside the abort is already committed by the arbiter.
          if (i_abort || (i_gnt && r_cnt == LW'(1)))
            r_state <= FILL_DONE;
        end
        FILL_DONE: r_state <= FILL_IDLE;
        default:   r_state <= FILL_IDLE;
      endcase
    end
  end

  assign o_req  = (r_state == FILL_RUN);
  assign o_busy = (r_state == FILL_RUN);
  assign o_done = (r_state == FILL_DONE);
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video fetch has absolute priority, CPU and
// fill engine share the remaining cycles round-robin; reads return at t+2.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW,
  parameter int LW = VRAM_LW
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  logic          w_fill_req;
  logic          w_fill_gnt;
  logic [AW-1:0] w_fill_addr;
  logic [DW-1:0] w_fill_data;
  logic          w_cpu_elig;
  req_id_t       w_gnt;

  logic          r_rr_fill;
  logic          r_cpu_inflight;
  logic          r_cpu_we;
  req_id_t       r_id_p1;
  req_id_t       r_id_p2;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [DW-1:0] r_mem_din;
  logic [DW-1:0] r_cpu_rdata;

  vram_fill_engine #(.AW(AW), .DW(DW), .LW(LW)) u_fill (
    .clk     (clk),
    .reset   (reset),
    .i_start (bus.fill_start),
    .i_abort (bus.fill_abort),
    .i_base  (bus.fill_base),
    .i_len   (bus.fill_len),
    .i_data  (bus.fill_data),
    .i_gnt   (w_fill_gnt),
    .o_req   (w_fill_req),
    .o_addr  (w_fill_addr),
    .o_data  (w_fill_data),
    .o_busy  (bus.fill_busy),
    .o_done  (bus.fill_done)
  );

  assign w_cpu_elig = bus.cpu_req & ~r_cpu_inflight;

  always_comb begin
    w_gnt = REQ_NONE;
    if (bus.vid_req)
      w_gnt = REQ_VID;
    else if (w_cpu_elig && w_fill_req)
      w_gnt = r_rr_fill ? REQ_FILL : REQ_CPU;
    else if (w_cpu_elig)
      w_gnt = REQ_CPU;
    else if (w_fill_req)
      w_gnt = REQ_FILL;
  end

  assign w_fill_gnt = (w_gnt == REQ_FILL);

  // Stage 1: winner onto the RAM pins; stage 2: requester ID meets mem_dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_fill      <= 1'b0;
      r_cpu_inflight <= 1'b0;
      r_cpu_we       <= 1'b0;
      r_id_p1        <= REQ_NONE;
      r_id_p2        <= REQ_NONE;
      r_mem_addr     <= '0;
      r_mem_we       <= 1'b0;
      r_mem_din      <= '0;
      r_cpu_rdata    <= '0;
    end else begin
      r_id_p1  <= w_gnt;
      r_id_p2  <= r_id_p1;
      r_mem_we <= 1'b0;
      case (w_gnt)
        REQ_VID: r_mem_addr <= bus.vid_addr;
        REQ_CPU: begin
          r_mem_addr <= bus.cpu_addr;
          r_mem_we   <= bus.cpu_we;
          r_mem_din  <= bus.cpu_wdata;
          r_rr_fill  <= 1'b1;
        end
        REQ_FILL: begin
          r_mem_addr <= w_fill_addr;
          r_mem_we   <= 1'b1;
          r_mem_din  <= w_fill_data;
          r_rr_fill  <= 1'b0;
        end
        default: ;
      endcase
      if (w_gnt == REQ_CPU) begin
        r_cpu_inflight <= 1'b1;
        r_cpu_we       <= bus.cpu_we;
      end else if (r_id_p2 == REQ_CPU) begin
        r_cpu_inflight <= 1'b0;
      end
      if (r_id_p2 == REQ_CPU && !r_cpu_we)
        r_cpu_rdata <= bus.mem_dout;
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_din    = r_mem_din;
  assign bus.vid_rvalid = (r_id_p2 == REQ_VID);
  assign bus.vid_rdata  = bus.vid_rvalid ? bus.mem_dout : '0;
  assign bus.cpu_ack    = (r_id_p2 == REQ_CPU);
  assign bus.cpu_rdata  = (bus.cpu_ack && !r_cpu_we) ? bus.mem_dout : r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a RAM model and queue scoreboards
// for video reads, CPU completions and the RAM write stream.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  ram [0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int n_vid  = 0;
  int n_done = 0;

  logic [7:0]  exp_vid [$];
  logic [8:0]  exp_cpu [$];
  logic [22:0] exp_w   [$];
  logic [22:0] obs_w   [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.vid_rvalid) begin
        n_vid++;
        if (exp_vid.size() == 0) chk("vid_unexpected", 64'(exp_vid.size()), 64'd1);
        else chk("vid_rdata", 64'(bus.vid_rdata), 64'(exp_vid.pop_front()));
      end
      if (bus.cpu_ack) begin
        if (exp_cpu.size() == 0) chk("cpu_ack_unexpected", 64'(exp_cpu.size()), 64'd1);
        else begin
          logic [8:0] e;
          e = exp_cpu.pop_front();
          if (e[8]) chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e[7:0]));
        end
      end
      if (bus.mem_we) obs_w.push_back({bus.mem_addr, bus.mem_din});
      if (bus.fill_done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic push_w(input logic [14:0] a, input logic [7:0] d);
    exp_w.push_back({a, d});
  endtask

  task automatic expect_writes(input string tag);
    chk({tag, "_wr_count"}, 64'(obs_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      chk({tag, "_wr"}, 64'(obs_w[i]), 64'(exp_w[i]));
    obs_w.delete();
    exp_w.delete();
  endtask

  task automatic start_fill(input logic [14:0] b, input logic [14:0] l, input logic [7:0] d);
    bus.fill_start = 1'b1; bus.fill_base = b; bus.fill_len = l; bus.fill_data = d;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.mem_addr, bus.mem_we, bus.mem_din, bus.vid_rvalid, bus.vid_rdata,
                bus.cpu_ack, bus.cpu_rdata, bus.fill_busy, bus.fill_done});
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, acks, v0, d0;
    bus.vid_req = 0; bus.vid_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.fill_start = 0; bus.fill_abort = 0;
    bus.fill_base = '0; bus.fill_len = '0; bus.fill_data = '0;

    // Reset held with random stimulus while the RAM is preloaded.
    preload(15'h0010, 8'hA5);
    preload(15'h0020, 8'h5A);
    for (int i = 0; i < 20; i++) begin
      bus.vid_req = 1'($urandom); bus.vid_addr = 15'($urandom);
      bus.cpu_req = 1'($urandom); bus.cpu_we = 1'($urandom);
      bus.cpu_addr = 15'($urandom); bus.fill_start = 1'($urandom);
      bus.fill_len = 15'($urandom); bus.fill_abort = 1'($urandom);
      preload(15'h0200 + 15'(i), 8'((i * 37 + 11) & 8'hFF));
    end
    chk("reset_outs", all_outs(), 64'd0);
    bus.vid_req = 0; bus.cpu_req = 0; bus.cpu_we = 0; bus.fill_start = 0;
    bus.fill_abort = 0; bus.fill_len = '0;
    reset = 1'b1;
    tick();
    chk("post_reset_outs", all_outs(), 64'd0);

    // CPU read latency.
    exp_cpu.push_back({1'b1, 8'hA5});
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0010;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); n++;
      if (bus.cpu_ack) break;
    end
    chk("cpu_ack_latency", 64'(n), 64'd2);
    chk("cpu_rdata_at_ack", 64'(bus.cpu_rdata), 64'hA5);
    bus.cpu_req = 0;
    tick();
    chk("cpu_ack_single", 64'(bus.cpu_ack), 64'd0);
    chk("cpu_rdata_hold", 64'(bus.cpu_rdata), 64'hA5);
    tick();

    // Video burst starves the CPU.
    v0 = n_vid; acks = 0;
    exp_cpu.push_back({1'b1, 8'h5A});
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0020;
    for (int i = 0; i < 20; i++) begin
      bus.vid_req = 1; bus.vid_addr = 15'h0200 + 15'(i);
      exp_vid.push_back(8'((i * 37 + 11) & 8'hFF));
      if (bus.cpu_ack) acks++;
      tick();
    end
    bus.vid_req = 0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.cpu_ack) break;
      tick(); n++;
    end
    bus.cpu_req = 0;
    chk("burst_no_ack", 64'(acks), 64'd0);
    chk("ack_after_burst", 64'(n), 64'd2);
    tick(); tick();
    chk("vid_pulses", 64'(n_vid - v0), 64'd20);
    chk("vid_queue_empty", 64'(exp_vid.size()), 64'd0);

    // Round-robin between CPU writes and a fill.
    d0 = n_done; acks = 0;
    start_fill(15'h0100, 15'd4, 8'h3C);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0300; bus.cpu_wdata = 8'h11;
    exp_cpu.push_back({1'b0, 8'h00}); exp_cpu.push_back({1'b0, 8'h00});
    push_w(15'h0300, 8'h11); push_w(15'h0100, 8'h3C); push_w(15'h0101, 8'h3C);
    push_w(15'h0301, 8'h22); push_w(15'h0102, 8'h3C); push_w(15'h0103, 8'h3C);
    tick();
    bus.fill_start = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.cpu_ack) begin
        if (acks == 0) begin bus.cpu_addr = 15'h0301; bus.cpu_wdata = 8'h22; end
        else bus.cpu_req = 0;
        acks++;
      end
      tick();
    end
    bus.cpu_req = 0; bus.cpu_we = 0;
    chk("rr_cpu_acks", 64'(acks), 64'd2);
    chk("rr_fill_done", 64'(n_done - d0), 64'd1);
    chk("rr_busy_clear", 64'(bus.fill_busy), 64'd0);
    expect_writes("rr");
    for (int i = 0; i < 4; i++) chk("rr_ram", 64'(ram[15'h0100 + 15'(i)]), 64'h3C);

    // Address wrap.
    d0 = n_done;
    start_fill(15'h7FFE, 15'd4, 8'h77);
    push_w(15'h7FFE, 8'h77); push_w(15'h7FFF, 8'h77);
    push_w(15'h0000, 8'h77); push_w(15'h0001, 8'h77);
    tick();
    bus.fill_start = 0;
    chk("wrap_busy", 64'(bus.fill_busy), 64'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("wrap_done", 64'(n_done - d0), 64'd1);
    expect_writes("wrap");

    // Zero length.
    start_fill(15'h0400, 15'd0, 8'hEE);
    tick();
    bus.fill_start = 0;
    chk("len0_done", 64'(bus.fill_done), 64'd1);
    chk("len0_busy", 64'(bus.fill_busy), 64'd0);
    tick();
    chk("len0_done_single", 64'(bus.fill_done), 64'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("len0_no_writes", 64'(obs_w.size()), 64'd0);

    // Abort after ten writes, with an ignored restart during RUN.
    d0 = n_done;
    start_fill(15'h1000, 15'd100, 8'h99);
    for (int i = 0; i < 11; i++) push_w(15'h1000 + 15'(i), 8'h99);
    for (int k = 1; k <= 11; k++) begin
      tick();
      bus.fill_start = 0;
      if (k == 5) start_fill(15'h2000, 15'd3, 8'h55);
      if (k == 11) bus.fill_abort = 1;
    end
    tick();
    bus.fill_abort = 0;
    chk("abort_done", 64'(bus.fill_done), 64'd1);
    tick();
    chk("abort_busy", 64'(bus.fill_busy), 64'd0);
    chk("abort_done_single", 64'(bus.fill_done), 64'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("abort_done_count", 64'(n_done - d0), 64'd1);
    expect_writes("abort");

    // Reset in the middle of a fill.
    d0 = n_done;
    start_fill(15'h4000, 15'd100, 8'h42);
    for (int k = 0; k < 50; k++) begin
      tick();
      bus.fill_start = 0;
    end
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.fill_busy), 64'd0);
    chk("midrst_we", 64'(bus.mem_we), 64'd0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    obs_w.delete();
    chk("midrst_no_done", 64'(n_done - d0), 64'd0);
    start_fill(15'h5000, 15'd3, 8'h24);
    push_w(15'h5000, 8'h24); push_w(15'h5001, 8'h24); push_w(15'h5002, 8'h24);
    tick();
    bus.fill_start = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("refill_done", 64'(n_done - d0), 64'd1);
    expect_writes("refill");
    chk("cpu_queue_empty", 64'(exp_cpu.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
